// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side register bus for the seven-segment controller.
// The CPU drives select, strobe, address and data; the controller returns read data.
interface seg7_scan_ctrl_if;
   logic        cs_7seg;
   logic        we;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output cs_7seg, we, address, wdata, input rdata);
   modport slave  (input cs_7seg, we, address, wdata, output rdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped four-digit common-anode seven-segment scan controller.
// DIGIT0..3 and CTRL live at word addresses 3..7, and reads return data combinationally.
module seg7_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_ctrl_if.slave   bus,
   output logic [3:0]        an_n,
   output logic [6:0]        seg_n,
   output logic              dp_n
);

   localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

   logic [4:0]         digit [4];
   logic [4:0]         ctrl;
   logic [PRESC_W-1:0] presc;
   logic [1:0]         digit_idx;

   logic               in_range;
   logic [2:0]         offset;
   logic               wr_en;
   logic [31:0]        rdata_c;
   logic [4:0]         cur_c;
   logic [3:0]         dp_mask;
   logic [6:0]         seg_c;
   logic               unused_wdata;

   assign in_range     = (bus.address >= 32'd3) && (bus.address <= 32'd7);
   assign offset       = 3'(bus.address - 32'd3);
   assign wr_en        = bus.cs_7seg && bus.we && in_range;
   assign unused_wdata = ^bus.wdata[31:5];
   assign dp_mask      = ctrl[4:1];
   assign cur_c        = digit[digit_idx];

   // Register file writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) digit[i] <= 5'h10;
         ctrl <= 5'h00;
      end else if (wr_en) begin
         if (offset == 3'd4) ctrl <= bus.wdata[4:0];
         else                digit[offset[1:0]] <= bus.wdata[4:0];
      end
   end

   // Side-effect-free combinational read path
   always_comb begin
      rdata_c = 32'd0;
      if (bus.cs_7seg && !bus.we && in_range) begin
         if (offset == 3'd4) rdata_c = {27'd0, ctrl};
         else                rdata_c = {27'd0, digit[offset[1:0]]};
      end
   end
   assign bus.rdata = rdata_c;

   // Free-running dwell prescaler and digit index, parked at 0 while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         digit_idx <= 2'd0;
      end else if (!ctrl[0]) begin
         presc     <= '0;
         digit_idx <= 2'd0;
      end else if (presc == PRESC_MAX) begin
         presc     <= '0;
         digit_idx <= 2'(digit_idx + 2'd1);
      end else begin
         presc     <= PRESC_W'(presc + 1'b1);
      end
   end

   // Active-low gfedcba hex font
   always_comb begin
      seg_c = 7'h7F;
      case (cur_c[3:0])
         4'h0: seg_c = 7'b1000000;
         4'h1: seg_c = 7'b1111001;
         4'h2: seg_c = 7'b0100100;
         4'h3: seg_c = 7'b0110000;
         4'h4: seg_c = 7'b0011001;
         4'h5: seg_c = 7'b0010010;
         4'h6: seg_c = 7'b0000010;
         4'h7: seg_c = 7'b1111000;
         4'h8: seg_c = 7'b0000000;
         4'h9: seg_c = 7'b0010000;
         4'hA: seg_c = 7'b0001000;
         4'hB: seg_c = 7'b0000011;
         4'hC: seg_c = 7'b1000110;
         4'hD: seg_c = 7'b0100001;
         4'hE: seg_c = 7'b0000110;
         4'hF: seg_c = 7'b0001110;
         default: seg_c = 7'h7F;
      endcase
   end

   // Registered drive stage; a blanked digit leaves its whole slot dark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n  <= 4'hF;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
      end else if (!ctrl[0] || cur_c[4]) begin
         an_n  <= 4'hF;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
      end else begin
         an_n  <= ~(4'b0001 << digit_idx);
         seg_n <= seg_c;
         dp_n  <= ~dp_mask[digit_idx];
      end
   end

endmodule
